// File: rtl/wb_grf.sv
// wb_grf: write-back stage and 32x32 general register file of the MIPS pipeline.
//   Extends load data, selects the write-back value (WDW) and commits it to the
//   register file. Also serves two combinational decode-stage read ports with a
//   write-to-read bypass, so a W->D hazard needs no stall.
// Ports:
//   clk, reset        clock; synchronous active-high reset clears all registers
//   InstrW, PCW       write-back instruction (opcode picks load extension) and PC
//   RegWriteW         register write enable
//   RegSrcW           00/11 ResultW, 01 extended load data, 10 PCW+RESET_PC_OFFSET
//   ReadDataW         raw aligned word from data memory
//   ResultW           ALU result / load byte address
//   RegDstW           destination register number
//   RA1, RA2          read addresses; RD1, RD2 read data (combinational)
//   WDW               selected write-back value (combinational, for forwarding)
// Optional feature: define GRF_TRACE_EN to print one trace line per accepted write.
module wb_grf #(
    parameter logic [31:0] RESET_PC_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrW,
    input  logic [31:0] PCW,
    input  logic        RegWriteW,
    input  logic [1:0]  RegSrcW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] ResultW,
    input  logic [4:0]  RegDstW,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] WDW
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_LINK = 2'b10;

    logic [XLEN-1:0] regs [NREG];
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] link_data;
    logic            wr_en;
    logic            byp1;
    logic            byp2;

    // Only the opcode field of the instruction matters here.
    logic unused_instr;
    assign unused_instr = ^InstrW[25:0];

    // Lane selection (little-endian lanes; halfword ignores address bit 0).
    always_comb begin
        load_byte = 8'h00;
        case (ResultW[1:0])
            2'd0:    load_byte = ReadDataW[7:0];
            2'd1:    load_byte = ReadDataW[15:8];
            2'd2:    load_byte = ReadDataW[23:16];
            default: load_byte = ReadDataW[31:24];
        endcase
        load_half = ResultW[1] ? ReadDataW[31:16] : ReadDataW[15:0];
    end

    // Load extension by opcode; unknown opcodes pass the word through.
    always_comb begin
        load_data = ReadDataW;
        case (InstrW[31:26])
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'h000000, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'h0000, load_half};
            OP_LW:   load_data = ReadDataW;
            default: load_data = ReadDataW;
        endcase
    end

    // Link value wraps modulo 2^32.
    assign link_data = XLEN'(PCW + RESET_PC_OFFSET);

    // Write-back value select.
    always_comb begin
        WDW = ResultW;
        case (RegSrcW)
            SRC_ALU:  WDW = ResultW;
            SRC_LOAD: WDW = load_data;
            SRC_LINK: WDW = link_data;
            default:  WDW = ResultW;
        endcase
    end

    assign wr_en = !reset && RegWriteW && (RegDstW != AW'(0));

    // Register array: reset wins over any concurrent write; $0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[RegDstW] <= WDW;
        end
    end

    // Read ports with write-to-read bypass (disabled during reset).
    assign byp1 = wr_en && (RA1 == RegDstW);
    assign byp2 = wr_en && (RA2 == RegDstW);

    always_comb begin
        RD1 = regs[RA1];
        if (RA1 == AW'(0)) begin
            RD1 = '0;
        end else if (byp1) begin
            RD1 = WDW;
        end
    end

    always_comb begin
        RD2 = regs[RA2];
        if (RA2 == AW'(0)) begin
            RD2 = '0;
        end else if (byp2) begin
            RD2 = WDW;
        end
    end

`ifdef GRF_TRACE_EN
    // Trace format matches the reference simulator log.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            $display("%d@%h: $%d <= %h", $time, PCW, RegDstW, WDW);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: table-driven bench for wb_grf plus a hand-written mid-stream reset sequence.
module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [31:0] InstrW;
    logic [31:0] PCW;
    logic        RegWriteW;
    logic [1:0]  RegSrcW;
    logic [31:0] ReadDataW;
    logic [31:0] ResultW;
    logic [4:0]  RegDstW;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WDW;

    int total;
    int bad;

    localparam logic [31:0] I_R   = 32'h0000_0000;
    localparam logic [31:0] I_LB  = 32'h8000_0000;
    localparam logic [31:0] I_LH  = 32'h8400_0000;
    localparam logic [31:0] I_LW  = 32'h8C00_0000;
    localparam logic [31:0] I_LBU = 32'h9000_0000;
    localparam logic [31:0] I_LHU = 32'h9400_0000;
    localparam logic [31:0] MEMW  = 32'h80FF_7F01;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        we;
        logic [1:0]  src;
        logic [31:0] rdata;
        logic [31:0] result;
        logic [4:0]  dst;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ew;
    } vec_t;

    vec_t vecs[$];

    wb_grf #(.RESET_PC_OFFSET(32'd8)) dut (
        .clk(clk), .reset(reset), .InstrW(InstrW), .PCW(PCW),
        .RegWriteW(RegWriteW), .RegSrcW(RegSrcW), .ReadDataW(ReadDataW),
        .ResultW(ResultW), .RegDstW(RegDstW), .RA1(RA1), .RA2(RA2),
        .RD1(RD1), .RD2(RD2), .WDW(WDW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic rst, input logic [31:0] instr, input logic [31:0] pc,
                       input logic we, input logic [1:0] src, input logic [31:0] rdata,
                       input logic [31:0] result, input logic [4:0] dst,
                       input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ew);
        vec_t v;
        v.rst = rst; v.instr = instr; v.pc = pc; v.we = we; v.src = src;
        v.rdata = rdata; v.result = result; v.dst = dst; v.ra1 = ra1; v.ra2 = ra2;
        v.e1 = e1; v.e2 = e2; v.ew = ew;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check outputs 1 ns later.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset = v.rst; InstrW = v.instr; PCW = v.pc; RegWriteW = v.we;
        RegSrcW = v.src; ReadDataW = v.rdata; ResultW = v.result;
        RegDstW = v.dst; RA1 = v.ra1; RA2 = v.ra2;
        #1;
        check({tag, "_rd1"}, RD1, v.e1);
        check({tag, "_rd2"}, RD2, v.e2);
        check({tag, "_wdw"}, WDW, v.ew);
    endtask

    initial begin
        vec_t s;
        total = 0;
        bad = 0;
        reset = 1'b1; InstrW = '0; PCW = '0; RegWriteW = 1'b0; RegSrcW = 2'b00;
        ReadDataW = '0; ResultW = '0; RegDstW = '0; RA1 = '0; RA2 = '0;

        //   rst  instr  pc            we  src    rdata  result        dst ra1 ra2  e1            e2            ew
        add(1'b1, I_R,   32'h0,        0, 2'b00, 32'h0, 32'h0,        0,  0,  0,  32'h0,        32'h0,        32'h0);
        add(1'b0, I_R,   32'h0,        0, 2'b00, 32'h0, 32'h0,        0,  5,  0,  32'h0,        32'h0,        32'h0);
        add(1'b0, I_R,   32'h0,        1, 2'b00, 32'h0, 32'h1234,     5,  5,  6,  32'h1234,     32'h0,        32'h1234);
        add(1'b0, I_R,   32'h0,        0, 2'b00, 32'h0, 32'h0,        0,  5,  0,  32'h1234,     32'h0,        32'h0);
        // reset with concurrent write: no bypass, stored values shown
        add(1'b1, I_R,   32'h0,        1, 2'b00, 32'h0, 32'h77,       9,  5,  9,  32'h1234,     32'h0,        32'h77);
        add(1'b0, I_R,   32'h0,        0, 2'b00, 32'h0, 32'h0,        0,  5,  9,  32'h0,        32'h0,        32'h0);
        add(1'b0, I_R,   32'h0,        1, 2'b00, 32'h0, 32'hDEADBEEF, 8,  8,  8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        add(1'b0, I_R,   32'h0,        0, 2'b00, 32'h0, 32'h0,        0,  8,  0,  32'hDEADBEEF, 32'h0,        32'h0);
        // load extension
        add(1'b0, I_LB,  32'h0,        1, 2'b01, MEMW,  32'h1003,     10, 10, 8,  32'hFFFFFF80, 32'hDEADBEEF, 32'hFFFFFF80);
        add(1'b0, I_LBU, 32'h0,        1, 2'b01, MEMW,  32'h1003,     11, 11, 10, 32'h00000080, 32'hFFFFFF80, 32'h00000080);
        add(1'b0, I_LH,  32'h0,        1, 2'b01, MEMW,  32'h1002,     12, 12, 11, 32'hFFFF80FF, 32'h00000080, 32'hFFFF80FF);
        add(1'b0, I_LHU, 32'h0,        1, 2'b01, MEMW,  32'h1000,     13, 13, 12, 32'h00007F01, 32'hFFFF80FF, 32'h00007F01);
        add(1'b0, I_LW,  32'h0,        1, 2'b01, MEMW,  32'h1001,     14, 14, 13, 32'h80FF7F01, 32'h00007F01, 32'h80FF7F01);
        add(1'b0, I_LB,  32'h0,        1, 2'b01, MEMW,  32'h1001,     15, 15, 14, 32'h0000007F, 32'h80FF7F01, 32'h0000007F);
        add(1'b0, I_LH,  32'h0,        1, 2'b01, MEMW,  32'h1003,     16, 16, 15, 32'hFFFF80FF, 32'h0000007F, 32'hFFFF80FF);
        add(1'b0, I_R,   32'h0,        1, 2'b01, MEMW,  32'h1002,     17, 17, 16, 32'h80FF7F01, 32'hFFFF80FF, 32'h80FF7F01);
        // link value, including wrap
        add(1'b0, I_R,   32'h00003004, 1, 2'b10, 32'h0, 32'h0,        31, 31, 17, 32'h0000300C, 32'h80FF7F01, 32'h0000300C);
        add(1'b0, I_R,   32'hFFFFFFFC, 1, 2'b10, 32'h0, 32'h0,        31, 31, 31, 32'h00000004, 32'h00000004, 32'h00000004);
        add(1'b0, I_R,   32'h0,        0, 2'b11, 32'h0, 32'hAB,       0,  31, 31, 32'h00000004, 32'h00000004, 32'hAB);
        // $0 discards writes
        add(1'b0, I_R,   32'h0,        1, 2'b00, 32'h0, 32'h55,       0,  0,  31, 32'h0,        32'h00000004, 32'h55);
        add(1'b0, I_R,   32'h0,        0, 2'b00, 32'h0, 32'h0,        0,  0,  0,  32'h0,        32'h0,        32'h0);
        // no bypass without write enable
        add(1'b0, I_R,   32'h0,        0, 2'b00, 32'h0, 32'h99,       20, 20, 20, 32'h0,        32'h0,        32'h99);
        add(1'b0, I_R,   32'h0,        1, 2'b11, 32'h0, 32'h99,       20, 20, 0,  32'h99,       32'h0,        32'h99);
        add(1'b0, I_R,   32'h0,        0, 2'b00, 32'h0, 32'h0,        0,  20, 0,  32'h99,       32'h0,        32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Mid-stream reset: write $3, hold reset two cycles with writes, then
        // the first edge with reset low must accept a write.
        s = vecs[0];
        s.rst = 1'b0; s.we = 1'b1; s.src = 2'b00; s.result = 32'hAAAA_5555; s.dst = 5'd3;
        s.ra1 = 5'd3; s.ra2 = 5'd4; s.e1 = 32'hAAAA_5555; s.e2 = 32'h0; s.ew = 32'hAAAA_5555;
        apply(s, "mr_wr3");
        s.rst = 1'b1; s.result = 32'h5; s.e1 = 32'hAAAA_5555; s.e2 = 32'h0; s.ew = 32'h5;
        apply(s, "mr_rst0");
        s.dst = 5'd4; s.result = 32'h6; s.e1 = 32'h0; s.e2 = 32'h0; s.ew = 32'h6;
        apply(s, "mr_rst1");
        s.rst = 1'b0; s.result = 32'h66; s.ra1 = 5'd4; s.ra2 = 5'd3; s.e1 = 32'h66; s.e2 = 32'h0; s.ew = 32'h66;
        apply(s, "mr_first");
        s.we = 1'b0; s.result = 32'h0; s.e1 = 32'h66; s.e2 = 32'h0; s.ew = 32'h0;
        apply(s, "mr_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
